// File: rtl/riscv_v_pkg.sv
// Shared vector-lane types: multiply opcodes and per-operand signedness helpers.
package riscv_v_pkg;

    typedef enum logic [1:0] {
        VMUL_LO  = 2'd0,
        VMUL_H   = 2'd1,
        VMUL_HU  = 2'd2,
        VMUL_HSU = 2'd3
    } vmul_op_t;

    // vs2 is signed for vmulh and vmulhsu
    function automatic logic f_vmul_op_signed_a(input vmul_op_t op);
        return (op == VMUL_H) || (op == VMUL_HSU);
    endfunction

    function automatic logic f_vmul_op_signed_b(input vmul_op_t op);
        return (op == VMUL_H);
    endfunction

endpackage

// File: rtl/vedic_mul_unsigned.sv
// Recursive Vedic (Urdhva-Tiryagbhyam) unsigned multiplier; splits into four half-width
// products until WIDTH reaches MIN_MUL_LEVEL, where a plain multiply takes over.
module vedic_mul_unsigned #(
    parameter int WIDTH                = 32,
    parameter int MIN_MUL_LEVEL        = 4,
    parameter int GET_MID_PREV_RESULTS = 0
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] result,
    output logic [WIDTH:0]     prev_result
);

    generate
        if (WIDTH <= MIN_MUL_LEVEL) begin : g_leaf
            assign result      = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
            assign prev_result = '0;
        end else begin : g_split
            localparam int H = WIDTH / 2;

            logic [WIDTH-1:0] ll, lh, hl, hh;
            logic [WIDTH:0]   mid;
            logic [H:0]       ll_unused, lh_unused, hl_unused, hh_unused;

            vedic_mul_unsigned #(.WIDTH(H), .MIN_MUL_LEVEL(MIN_MUL_LEVEL), .GET_MID_PREV_RESULTS(0)) u_ll (
                .a(a[H-1:0]), .b(b[H-1:0]), .result(ll), .prev_result(ll_unused));
            vedic_mul_unsigned #(.WIDTH(H), .MIN_MUL_LEVEL(MIN_MUL_LEVEL), .GET_MID_PREV_RESULTS(0)) u_lh (
                .a(a[H-1:0]), .b(b[WIDTH-1:H]), .result(lh), .prev_result(lh_unused));
            vedic_mul_unsigned #(.WIDTH(H), .MIN_MUL_LEVEL(MIN_MUL_LEVEL), .GET_MID_PREV_RESULTS(0)) u_hl (
                .a(a[WIDTH-1:H]), .b(b[H-1:0]), .result(hl), .prev_result(hl_unused));
            vedic_mul_unsigned #(.WIDTH(H), .MIN_MUL_LEVEL(MIN_MUL_LEVEL), .GET_MID_PREV_RESULTS(0)) u_hh (
                .a(a[WIDTH-1:H]), .b(b[WIDTH-1:H]), .result(hh), .prev_result(hh_unused));

            // Cross terms carry one extra bit before being shifted into the middle
            assign mid         = {1'b0, lh} + {1'b0, hl};
            assign result      = {hh, ll} + ({{(WIDTH-1){1'b0}}, mid} << H);
            assign prev_result = (GET_MID_PREV_RESULTS != 0) ? mid : '0;
        end
    endgenerate

endmodule

// File: rtl/vmul_sign_cond.sv
// Operand conditioning: magnitude and sign of a value that may be read as signed.
module vmul_sign_cond #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             is_signed,
    output logic [WIDTH-1:0] mag,
    output logic             sign
);

    // The most negative value maps to 2^(WIDTH-1), still representable unsigned
    assign sign = is_signed & value[WIDTH-1];
    assign mag  = sign ? (~value + 1'b1) : value;

endmodule

// File: rtl/vedic_mul_pipe.sv
// Three-stage RVV integer multiply (vmul/vmulh/vmulhu/vmulhsu) around an unsigned
// Vedic multiplier, with valid/ready on both sides and a global stall.
module vedic_mul_pipe
    import riscv_v_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int TAG_WIDTH     = 5,
    parameter int MIN_MUL_LEVEL = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  vmul_op_t             in_op,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [TAG_WIDTH-1:0] in_tag,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 busy
);

    function automatic logic [WIDTH-1:0] f_restore_half(input vmul_op_t op, input logic neg,
                                                        input logic [2*WIDTH-1:0] prod);
        logic signed [2*WIDTH-1:0] p;
        p = neg ? -$signed(prod) : $signed(prod);
        return (op == VMUL_LO) ? p[WIDTH-1:0] : p[2*WIDTH-1:WIDTH];
    endfunction

    logic                 stall, take;
    logic                 s1_v, s2_v, s3_v;
    logic                 sign_a, sign_b;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH-1:0]     mag_a_p1, mag_b_p1;
    vmul_op_t             op_p1, op_p2;
    logic [TAG_WIDTH-1:0] tag_p1, tag_p2;
    logic                 neg_p1, neg_p2;
    logic [2*WIDTH-1:0]   prod, prod_p2;
    logic [WIDTH:0]       prev_result_unused;

    assign stall     = s3_v & ~out_ready;
    assign in_ready  = ~stall;
    assign take      = in_valid & ~stall;
    assign out_valid = s3_v;
    assign busy      = s1_v | s2_v | s3_v;

    vmul_sign_cond #(.WIDTH(WIDTH)) u_cond_a (
        .value(in_a), .is_signed(f_vmul_op_signed_a(in_op)), .mag(mag_a), .sign(sign_a));
    vmul_sign_cond #(.WIDTH(WIDTH)) u_cond_b (
        .value(in_b), .is_signed(f_vmul_op_signed_b(in_op)), .mag(mag_b), .sign(sign_b));

    // Stage 1: conditioned magnitudes
    always_ff @(posedge clk) begin
        if (take) begin
            mag_a_p1 <= mag_a;
            mag_b_p1 <= mag_b;
            op_p1    <= in_op;
            tag_p1   <= in_tag;
            neg_p1   <= sign_a ^ sign_b;
        end
    end

    vedic_mul_unsigned #(
        .WIDTH(WIDTH), .MIN_MUL_LEVEL(MIN_MUL_LEVEL), .GET_MID_PREV_RESULTS(0)
    ) u_mul (
        .a(mag_a_p1), .b(mag_b_p1), .result(prod), .prev_result(prev_result_unused));

    // Stage 2: unsigned product
    always_ff @(posedge clk) begin
        if (!stall && s1_v) begin
            prod_p2 <= prod;
            op_p2   <= op_p1;
            tag_p2  <= tag_p1;
            neg_p2  <= neg_p1;
        end
    end

    // Stage 3: sign restore and half select; flush kills everything regardless of stall
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v     <= 1'b0;
            s2_v     <= 1'b0;
            s3_v     <= 1'b0;
            out_data <= '0;
            out_tag  <= '0;
        end else begin
            if (flush) begin
                s1_v <= 1'b0;
                s2_v <= 1'b0;
                s3_v <= 1'b0;
            end else if (!stall) begin
                s1_v <= in_valid;
                s2_v <= s1_v;
                s3_v <= s2_v;
            end
            if (!stall && s2_v) begin
                out_data <= f_restore_half(op_p2, neg_p2, prod_p2);
                out_tag  <= tag_p2;
            end
        end
    end

endmodule

// File: tb/tb_vedic_mul_pipe.sv
// Scoreboard bench for vedic_mul_pipe at WIDTH=8: directed corners, stall, flush,
// reset, then a random sweep against an integer reference model.
module tb_vedic_mul_pipe;
    import riscv_v_pkg::*;

    localparam int W  = 8;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    vmul_op_t      in_op = VMUL_LO;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic [TW-1:0] in_tag = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic [TW-1:0] out_tag;
    logic          busy;

    int total = 0;
    int bad   = 0;
    logic [W+TW-1:0] sb[$];
    logic rand_ready = 1'b0;
    logic arm_stall  = 1'b0;
    int   stall_cnt  = 0;

    vedic_mul_pipe #(.WIDTH(W), .TAG_WIDTH(TW), .MIN_MUL_LEVEL(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag), .busy(busy));

    always #5 clk = ~clk;

    // Reference: integer product of the operands as the opcode interprets them
    function automatic logic [W+TW-1:0] model(input vmul_op_t op, input logic [W-1:0] a,
                                              input logic [W-1:0] b, input logic [TW-1:0] tag);
        int x, y;
        logic [31:0] p;
        x = (op == VMUL_H || op == VMUL_HSU) ? int'($signed(a)) : int'(a);
        y = (op == VMUL_H) ? int'($signed(b)) : int'(b);
        p = x * y;
        return {(op == VMUL_LO) ? p[7:0] : p[15:8], tag};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic issue(input vmul_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TW-1:0] tag);
        int guard;
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        #1;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk); #1;
            guard++;
        end
        if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
        else sb.push_back(model(op, a, b, tag));
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("drain_timeout", sb.size(), 32'd0);
    endtask

    // Consumer: drives out_ready and forces one 5-cycle stall when armed
    initial begin
        forever begin
            @(negedge clk);
            if (stall_cnt > 0) begin
                out_ready = 1'b0;
                stall_cnt--;
                #1 check("in_ready_stall", in_ready, 1'b0);
            end else if (arm_stall && out_valid) begin
                arm_stall = 1'b0;
                stall_cnt = 4;
                out_ready = 1'b0;
                #1 check("in_ready_stall", in_ready, 1'b0);
            end else begin
                out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    // Monitor: pops on every completed output handshake, checks hold while stalled
    initial begin
        logic          held;
        logic [W-1:0]  hd;
        logic [TW-1:0] ht;
        logic [W+TW-1:0] exp_v;
        held = 1'b0; hd = '0; ht = '0;
        forever begin
            @(negedge clk); #2;
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held) check("hold", {out_valid, out_data, out_tag}, {1'b1, hd, ht});
                held = 1'b0;
                if (out_valid && !out_ready) begin
                    held = 1'b1; hd = out_data; ht = out_tag;
                end else if (out_valid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", {out_data, out_tag}, 32'hFFFF_FFFF);
                    end else begin
                        exp_v = sb.pop_front();
                        check("result", {out_data, out_tag}, exp_v);
                    end
                end
            end
        end
    end

    initial begin
        vmul_op_t op;
        logic [W-1:0] a, b;
        logic [W-1:0] corners [4];
        corners[0] = 8'h00; corners[1] = 8'h80; corners[2] = 8'h7F; corners[3] = 8'hFF;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_tag", out_tag, 5'd0);

        // Exact latency on the first op
        issue(VMUL_H, 8'h80, 8'h80, 5'd3);
        @(negedge clk); in_valid = 1'b0; #3 check("lat_c1", out_valid, 1'b0);
        @(negedge clk); #3 check("lat_c2", out_valid, 1'b0);
        @(negedge clk); #3 check("lat_c3", out_valid, 1'b1);
        drain();

        issue(VMUL_H, 8'h80, 8'h7F, 5'd4);
        issue(VMUL_LO, 8'h80, 8'h80, 5'd5);
        issue(VMUL_HU, 8'hFF, 8'hFF, 5'd6);
        issue(VMUL_HSU, 8'hFF, 8'hFF, 5'd7);
        issue(VMUL_LO, 8'hFF, 8'hFF, 5'd8);
        issue(VMUL_H, 8'h00, 8'h85, 5'd9);
        idle();
        drain();

        // Backpressure: four back-to-back ops with a 5-cycle stall on the first result
        arm_stall = 1'b1;
        for (int t = 1; t <= 4; t++) issue(VMUL_H, W'($urandom), W'($urandom), TW'(t));
        idle();
        drain();

        // Flush with two ops in flight and a third accepted alongside it
        issue(VMUL_HU, 8'h12, 8'h34, 5'd10);
        issue(VMUL_LO, 8'h56, 8'h78, 5'd11);
        @(negedge clk);
        in_valid = 1'b1; in_op = VMUL_H; in_a = 8'h9A; in_b = 8'hBC; in_tag = 5'd12; flush = 1'b1;
        sb.delete();
        #1 check("flush_in_ready", in_ready, 1'b1);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_busy", busy, 1'b0);
        check("flush_out_valid", out_valid, 1'b0);
        repeat (5) @(negedge clk);
        issue(VMUL_HU, 8'hFF, 8'hFF, 5'd13);
        idle();
        drain();

        // Reset with two ops in flight
        issue(VMUL_LO, 8'hFF, 8'hFF, 5'd14);
        issue(VMUL_H, 8'h80, 8'h80, 5'd15);
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        sb.delete();
        @(negedge clk);
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_out_data", out_data, 8'h00);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // Random sweep with random backpressure and input bubbles
        rand_ready = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                idle();
            end else begin
                op = vmul_op_t'($urandom_range(0, 3));
                a  = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom);
                b  = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom);
                issue(op, a, b, TW'($urandom));
            end
        end
        idle();
        drain();
        rand_ready = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
